// File: rtl/uart_rx_core.sv
// UART receiver with built-in baud tick generator and 16x oversampling, LSB first.
// Optional parity stage compiled in with `define UART_RX_PARITY_EN.
module uart_rx_core #(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned DVSR       = 163,
  parameter int unsigned DVSR_W     = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err,
  output logic            s_tick
);

  // s normally fits in 4 bits; widened only so 1.5/2 stop-bit settings can reach SB_TICK-1
  localparam int unsigned S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  logic              rx_meta_q, rx_meta_d;
  logic              rx_s_q, rx_s_d;
  logic              rx_s_d_q, rx_s_d_d;
  logic [DVSR_W-1:0] cnt_q, cnt_d;
  logic              tick_q, tick_d;
  state_e            state_q, state_d;
  logic [S_W-1:0]    s_q, s_d;
  logic [N_W-1:0]    n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              done_q, done_d;
  logic              fe_q, fe_d;
  logic [DBIT:0]     shift_w;

`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              pe_q, pe_d;
`endif

  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_s_d_d  = rx_s_q;
  end

  always_comb begin
    if (cnt_q == DVSR_W'(DVSR - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + DVSR_W'(1);
      tick_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    fe_d    = fe_q;
    shift_w = {rx_s_q, b_q};
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pe_d    = pe_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // only a genuine high-to-low transition starts a frame, never a static low
        if (rx_s_d_q && !rx_s_q) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (tick_q) begin
          if (s_q == S_W'(7)) begin
            if (!rx_s_q) begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick_q) begin
          if (s_q == S_W'(15)) begin
            s_d = '0;
            b_d = shift_w[DBIT:1];
            if (n_q == N_W'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + N_W'(1);
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_q) begin
          if (s_q == S_W'(15)) begin
            par_d   = (^b_q) ^ rx_s_q ^ PARITY_ODD[0];
            state_d = ST_STOP;
            s_d     = '0;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick_q) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            dout_d  = b_q;
            fe_d    = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            pe_d    = par_q;
`endif
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_s_d_q  <= 1'b1;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      fe_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_s_d_q  <= rx_s_d_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      fe_q      <= fe_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = fe_q;
  assign s_tick       = tick_q;

`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = PARITY_ODD[0];
  assign parity_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at DVSR=4 (64 clk per bit); a negedge monitor
// checks each done tick against a queue of frames pushed as they are sent.
module tb_uart_rx_core;

  localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = (9 + P) * BIT_CLK + 32;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;
  logic       s_tick;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];

  uart_rx_core #(
    .DBIT(8),
    .SB_TICK(16),
    .DVSR(4),
    .DVSR_W(8),
    .PARITY_ODD(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .dout(dout),
    .rx_done_tick(rx_done_tick),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .s_tick(s_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      check("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = cyc - e.t0;
        check("dout", 32'(dout), 32'(e.d));
        check("frame_err", 32'(frame_err), 32'(e.fe));
        check("parity_err", 32'(parity_err), 32'(e.pe));
        check("latency_window", 32'(lat >= LAT - 8 && lat <= LAT + 16), 32'd1);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
    exp_t e;
    logic pbit;
    @(posedge clk);
    #1;
    rx   = 1'b0;
    e.d  = d;
    e.fe = ~stop_b;
    e.pe = (P == 1) ? ~par_ok : 1'b0;
    e.t0 = cyc;
    sb.push_back(e);
    hold(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      hold(BIT_CLK);
    end
    if (P == 1) begin
      pbit = (^d) ^ ~par_ok;
      rx   = pbit;
      hold(BIT_CLK);
    end
    rx = stop_b;
    hold(BIT_CLK - 2);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int ticks;
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_done", 32'(rx_done_tick), 32'h0);
    check("rst_fe", 32'(frame_err), 32'h0);
    check("rst_pe", 32'(parity_err), 32'h0);
    check("rst_stick", 32'(s_tick), 32'h0);
    @(posedge clk);
    #1 reset = 1'b1;

    ticks = 0;
    hold(8);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ticks += int'(s_tick);
    end
    check("stick_rate", 32'(ticks), 32'd10);

    send_frame(8'h55, 1'b1, 1'b1);
    wait_drain("drain_55");
    hold(100);

    send_frame(8'hA3, 1'b1, 1'b1);
    send_frame(8'h0F, 1'b1, 1'b1);
    wait_drain("drain_b2b");
    hold(100);

    rx = 1'b0;
    hold(20);
    rx = 1'b1;
    hold(300);
    check("glitch_dout_hold", 32'(dout), 32'h0F);
    check("glitch_fe_hold", 32'(frame_err), 32'h0);

    send_frame(8'hC4, 1'b0, 1'b1);
    hold(3 * 10 * BIT_CLK);
    wait_drain("drain_break");
    check("break_dout", 32'(dout), 32'hC4);
    check("break_fe", 32'(frame_err), 32'h1);
    rx = 1'b1;
    hold(100);
    send_frame(8'h12, 1'b1, 1'b1);
    wait_drain("drain_12");
    check("after_break_fe", 32'(frame_err), 32'h0);
    hold(100);

    rx = 1'b0;
    hold(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      hold(BIT_CLK);
    end
    hold(BIT_CLK / 2);
    reset = 1'b0;
    hold(5);
    check("midrst_dout", 32'(dout), 32'h0);
    check("midrst_fe", 32'(frame_err), 32'h0);
    check("midrst_done", 32'(rx_done_tick), 32'h0);
    reset = 1'b1;
    hold(2 * 10 * BIT_CLK);
    check("aborted_dout", 32'(dout), 32'h0);
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_drain("drain_3c");
    hold(100);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    wait_drain("drain_par_ok");
    check("par_ok_pe", 32'(parity_err), 32'h0);
    hold(100);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_drain("drain_par_bad");
    check("par_bad_pe", 32'(parity_err), 32'h1);
    check("par_bad_dout", 32'(dout), 32'h07);
    hold(100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART serial receiver with an integrated baud-tick generator and 16x oversampling.
- Converts the asynchronous `rx` line into parallel bytes, LSB first.
- Sits directly upstream of the receive flag buffer: `rx_done_tick` drives the buffer's set input and `dout` drives its data input.
- Reports framing errors, and optionally parity errors, alongside each received word.

Parameters:
- DBIT, 8, number of data bits per frame.
- SB_TICK, 16, oversample ticks spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- DVSR, 163, clk cycles per oversample tick (50 MHz / (16 × 19200)); legal range is DVSR ≥ 2.
- DVSR_W, 8, width of the baud counter; must satisfy 2^DVSR_W ≥ DVSR.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- rx  in  1  serial line; asynchronous to clk; idles high.
- dout  out  DBIT  last received data word.
- rx_done_tick  out  1  one-clk pulse; `dout`, `frame_err` and `parity_err` are valid from this cycle.
- frame_err  out  1  stop bit of the last frame was sampled 0.
- parity_err  out  1  parity mismatch on the last frame; tied 0 without UART_RX_PARITY_EN.
- s_tick  out  1  oversample tick, exported for a companion transmitter.

Behaviour:
- Reset (reset = 0): baud counter = 0, FSM = IDLE, s = 0, n = 0, shift register = 0, dout = 0, rx_done_tick = 0, frame_err = 0, parity_err = 0, s_tick = 0.
  - Both synchronizer flops and the edge-detect register reset to 1 (line idle).
  - Asserting reset mid-frame aborts the frame; no done tick is produced.
- Synchronizer: `rx` passes through 2 flops to give rx_s; a third register holds rx_s_d for edge detection.
- Baud generator: free-running counter 0..DVSR-1, wraps to 0. `s_tick` = 1 for exactly one clk when count = DVSR-1; the tick is registered.
- FSM states: IDLE, START, DATA, [PARITY], STOP. The counters s (4 bits) and n (width of DBIT) advance only on s_tick.
  - IDLE: on a falling edge (rx_s_d = 1, rx_s = 0) go to START and clear s. A line already low at reset release, or held low after a frame, does NOT start a frame.
  - START: on s_tick with s = 7 (mid start bit):
    - rx_s = 0: go to DATA, clear s and n.
    - rx_s = 1: glitch; return to IDLE with no outputs.
    - Otherwise s increments.
  - DATA: on s_tick with s = 15, shift rx_s into the MSB of the shift register (right shift, so LSB arrives first) and clear s.
    - If n = DBIT-1, go to PARITY (macro on) or STOP; else n increments.
  - PARITY (macro on only): on s_tick with s = 15, latch the parity check and go to STOP with s cleared.
  - STOP: on s_tick with s = SB_TICK-1, return to IDLE and in the same clk:
    - pulse rx_done_tick;
    - load dout from the shift register;
    - set frame_err = ~rx_s;
    - set parity_err = the latched check (0 without macro).
- Output hold: dout, frame_err and parity_err hold until the next rx_done_tick. The data word is delivered even when frame_err = 1.
- Latency: rx_done_tick occurs (DBIT + 1 + P) × 16 × DVSR + 8 × DVSR + (SB_TICK − 16) × DVSR clks after the start-bit falling edge seen at rx_s, ±1 tick; P = 1 with parity, 0 without.
- Break (line held low): one frame completes with dout = 0 and frame_err = 1. No further frames until the line returns high and falls again.
- Back-to-back frames: the next start edge is accepted from the first clk after returning to IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state is present; the frame is start + DBIT data + 1 parity + stop.
  - The check is XOR of the data bits and the parity bit, XOR PARITY_ODD. A result of 1 sets parity_err on the done tick.
- Undefined:
  - No PARITY state; the frame is start + DBIT data + stop.
  - parity_err is constant 0.
  - The parity logic is not synthesized.

Test Plan:
- Set DVSR = 4 (bit = 64 clk). Send 0x55 with a valid stop → exactly one rx_done_tick, dout = 0x55, frame_err = 0.
- Send 0xA3 then 0x0F back-to-back with no idle gap → two done ticks, dout = 0xA3 then 0x0F, both frame_err = 0.
- Send a 20-clk low glitch on idle rx → FSM returns to IDLE, no done tick, dout unchanged.
- Send 0xC4 with stop bit = 0, then hold rx low for 3 frame times → one done tick with dout = 0xC4 and frame_err = 1, no further ticks. Release high and send 0x12 → dout = 0x12, frame_err = 0.
- Assert reset at data bit 4 of 0xFF, release, then send 0x3C → no tick for the aborted frame; dout = 0 after reset, then 0x3C.
- With UART_RX_PARITY_EN and PARITY_ODD = 0:
  - Send 0x07 with parity bit 1 → parity_err = 0.
  - Send 0x07 with parity bit 0 → parity_err = 1 and dout = 0x07.
